multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Parametrised control sequencer for the multi-cycle LoongArch core.
- Owns the PC, the instruction register and the IF/ID/EXE/MEM/WB state machine. SRAM access latency is configurable.
- Drives inst/data SRAM enables, register-file write enable, branch redirect and the debug trace.
- Sits between `mycpu_top` glue and the combinational decoder, regfile and ALU datapath.

Parameters:
- IMEM_LAT, 1, inst SRAM read latency in cycles (1..15).
- DMEM_LAT, 1, data SRAM read latency in cycles (1..15). Stores always take 1 cycle.
- PC_RESET, 32'h1c000000, PC value after reset.
- SKIP_MEM, 1, 1 = non-load/store instructions go EXE->WB; 0 = they pass one idle MEM cycle.
- CNT_W, 32, width of the cycle and retired-instruction counters.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- inst_sram_rdata  in  32  instruction read data
- dec_is_load  in  1  decoded from ir: ld.w
- dec_is_store  in  1  decoded from ir: st.w
- dec_gr_we  in  1  decoded from ir: instruction writes GPR
- br_taken  in  1  branch decision, valid in EXE
- br_target  in  32  branch target, valid in EXE
- pc  out  32  current instruction PC
- ir  out  32  latched instruction
- inst_sram_en  out  1  inst read request; address = pc
- data_sram_en  out  1  data access request
- data_sram_we  out  1  data write strobe
- mem_rdata_we  out  1  datapath latches data_sram_rdata this cycle
- exe_we  out  1  datapath latches alu_result this cycle
- rf_we  out  1  register-file write
- state  out  3  IF=0 ID=1 EXE=2 MEM=3 WB=4
- retire  out  1  one-cycle pulse at instruction completion
- cycle_cnt  out  CNT_W  cycles since reset
- instret_cnt  out  CNT_W  retired instructions
- debug_wb_pc  out  32  pc when rf_we, else 0
- debug_wb_rf_we  out  4  {4{rf_we}}

Behaviour:
- Reset (checked on clk edge, highest priority, may occur in any state):
  - state=IF, pc=PC_RESET, ir=0, latency counter=0, both counters=0.
  - All strobes 0; the in-flight instruction is abandoned with no rf_we or data_sram_we.
- IF:
  - inst_sram_en=1 in every IF cycle.
  - Latency counter counts 0..IMEM_LAT-1. On the last count: ir<=inst_sram_rdata, state->ID.
  - With IMEM_LAT=1, IF lasts exactly one cycle.
- ID: one cycle. Decoder inputs are combinational on ir. Sample dec_is_load, dec_is_store and dec_gr_we into internal flags. ->EXE.
- EXE: one cycle.
  - exe_we=1.
  - Latch br_taken and br_target into br_taken_q and br_target_q. br_target[1:0] is forced to 00.
  - Next state: MEM if load, store or SKIP_MEM=0; otherwise WB.
- MEM:
  - Store: data_sram_en=1 and data_sram_we=1 for exactly one cycle, then ->WB.
  - Load: data_sram_en=1 for DMEM_LAT cycles. mem_rdata_we=1 on the last cycle. ->WB.
  - Other instruction (SKIP_MEM=0): one idle cycle with no strobes, ->WB.
- WB: one cycle.
  - rf_we=gr_we_q; retire=1.
  - pc<=br_taken_q ? br_target_q : pc+4, with 32-bit wrap.
  - instret_cnt++. ->IF.
- Strobe timing: strobes are combinational from state and counter. Only one of inst_sram_en and data_sram_en is ever high.
- Latency with IMEM_LAT=DMEM_LAT=1, SKIP_MEM=1:
  - ALU op or branch: 4 cycles (IF, ID, EXE, WB).
  - Load or store: 5 cycles.
  - General load: IMEM_LAT+DMEM_LAT+3 cycles.
- Counters: cycle_cnt increments every non-reset cycle. Both counters wrap modulo 2^CNT_W silently.
- Illegal state encodings (5..7) go to IF without retiring.
- dec_is_load and dec_is_store both high is not a legal decode. Load takes priority.

Decomposition:
- Shared package `mc_pkg`:
  - State encoding localparams ST_IF..ST_WB.
  - PC_RESET default.
  - Latency counter width: 4 bits, sized for a maximum latency of 15.
- One natural sub-module, `lat_counter`: parametrised down-counter with load, enable and done flag. Instantiated once and reused by IF and MEM.
- The FSM, PC, IR and perf counters stay in `multicycle_ctrl`.

Test Plan:
- Reset released, defaults, ir=0x02800421 (addi.w), dec_gr_we=1:
  - pc=0x1c000000; state sequence 0,1,2,4.
  - rf_we=1 at cycle 4; pc=0x1c000004 at cycle 5; instret_cnt=1.
- IMEM_LAT=3, DMEM_LAT=2, load instruction:
  - inst_sram_en high 3 cycles; data_sram_en high 2 cycles.
  - mem_rdata_we on the 2nd data cycle; retire at cycle 8.
- Store:
  - data_sram_we high exactly 1 cycle in MEM; rf_we=0 in WB.
  - pc advances by 4.
- Branch, br_taken=1, br_target=0x1c000103 in EXE; inputs changed afterwards:
  - next pc=0x1c000100 (latched, low bits cleared).
  - Same with br_taken=0 -> pc+4.
- Reset asserted during MEM of a store:
  - data_sram_we drops in the same cycle; state=IF, pc=PC_RESET.
  - No rf_we or retire.
- SKIP_MEM=0 with an ALU op:
  - 5-cycle instruction with an idle MEM cycle and no data strobes.
  - CNT_W=4: counters wrap 15->0 after 16 retirements.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared state encoding, reset PC and latency-counter sizing for the multicycle core
package mc_pkg;
  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_e;
  localparam logic [31:0] PC_RESET_DEF = 32'h1c000000;
  localparam int LAT_W = 4;
endpackage

// File: rtl/lat_counter.sv
// lat_counter: down-counter that loads len_i on the first enabled cycle and flags the last one
module lat_counter
  import mc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [LAT_W-1:0] len_i,
  output logic             done_o
);
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             busy;
  // zero means idle, so a phase of length 1 never leaves the idle value
  always_comb begin
    busy   = cnt_q != '0;
    done_o = en_i && (busy ? cnt_q == LAT_W'(1) : len_i <= LAT_W'(1));
    cnt_d  = !en_i ? cnt_q : busy ? cnt_q - LAT_W'(1) : len_i <= LAT_W'(1) ? '0 : len_i - LAT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EXE/MEM/WB sequencer owning PC, IR, SRAM strobes and perf counters
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int          IMEM_LAT = 1,
  parameter int          DMEM_LAT = 1,
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          SKIP_MEM = 1,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst_sram_rdata,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_gr_we,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic [31:0]      pc,
  output logic [31:0]      ir,
  output logic             inst_sram_en,
  output logic             data_sram_en,
  output logic             data_sram_we,
  output logic             mem_rdata_we,
  output logic             exe_we,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we
);
  state_e             state_q, state_d;
  logic [31:0]        pc_q, ir_q, br_target_q;
  logic               ld_q, st_q, gr_we_q, br_taken_q;
  logic [CNT_W-1:0]   cyc_q, ret_q;
  logic               lat_en, lat_done, live;
  logic [LAT_W-1:0]   lat_len;

  lat_counter u_lat (
    .clk   (clk),
    .rst   (reset),
    .en_i  (lat_en),
    .len_i (lat_len),
    .done_o(lat_done)
  );

  always_comb begin
    lat_en  = state_q == ST_IF || (state_q == ST_MEM && ld_q);
    lat_len = state_q == ST_IF ? LAT_W'(IMEM_LAT) : LAT_W'(DMEM_LAT);
    state_d = ST_IF;
    case (state_q)
      ST_IF:   state_d = lat_done ? ST_ID : ST_IF;
      ST_ID:   state_d = ST_EXE;
      ST_EXE:  state_d = (ld_q || st_q || SKIP_MEM == 0) ? ST_MEM : ST_WB;
      ST_MEM:  state_d = (!ld_q || lat_done) ? ST_WB : ST_MEM;
      default: state_d = ST_IF;
    endcase
  end

  // reset kills every strobe in the same cycle so an abandoned store never writes
  always_comb begin
    live           = !reset;
    inst_sram_en   = live && state_q == ST_IF;
    data_sram_en   = live && state_q == ST_MEM && (ld_q || st_q);
    data_sram_we   = live && state_q == ST_MEM && st_q;
    mem_rdata_we   = live && state_q == ST_MEM && ld_q && lat_done;
    exe_we         = live && state_q == ST_EXE;
    retire         = live && state_q == ST_WB;
    rf_we          = retire && gr_we_q;
    debug_wb_pc    = rf_we ? pc_q : 32'd0;
    debug_wb_rf_we = {4{rf_we}};
    pc             = pc_q;
    ir             = ir_q;
    state          = state_q;
    cycle_cnt      = cyc_q;
    instret_cnt    = ret_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IF;
      pc_q        <= PC_RESET;
      ir_q        <= '0;
      ld_q        <= 1'b0;
      st_q        <= 1'b0;
      gr_we_q     <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      cyc_q       <= '0;
      ret_q       <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_q + CNT_W'(1);
      if (state_q == ST_IF && lat_done) ir_q <= inst_sram_rdata;
      if (state_q == ST_ID) begin
        ld_q    <= dec_is_load;
        st_q    <= dec_is_store && !dec_is_load;
        gr_we_q <= dec_gr_we;
      end
      if (state_q == ST_EXE) begin
        br_taken_q  <= br_taken;
        br_target_q <= {br_target[31:2], 2'b00};
      end
      if (state_q == ST_WB) begin
        pc_q  <= br_taken_q ? br_target_q : pc_q + 32'd4;
        ret_q <= ret_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction streams on two configurations against a phase-level model
module tb_multicycle_ctrl;
  localparam logic [31:0] PCR = 32'h1c000000;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], dld[2], dst[2], dwe[2], dbt[2];
  logic [31:0] rdata[2], dbtg[2];
  logic [31:0] o_pc[2], o_ir[2], o_dpc[2];
  logic        o_ien[2], o_den[2], o_dwe[2], o_mwe[2], o_exe[2], o_rfwe[2], o_ret[2];
  logic [2:0]  o_st[2];
  logic [3:0]  o_dwe4[2];
  logic [31:0] o_cyc0, o_ret0;
  logic [3:0]  o_cyc1, o_ret1;

  multicycle_ctrl u0 (
    .clk(clk), .reset(rst[0]), .inst_sram_rdata(rdata[0]), .dec_is_load(dld[0]),
    .dec_is_store(dst[0]), .dec_gr_we(dwe[0]), .br_taken(dbt[0]), .br_target(dbtg[0]),
    .pc(o_pc[0]), .ir(o_ir[0]), .inst_sram_en(o_ien[0]), .data_sram_en(o_den[0]),
    .data_sram_we(o_dwe[0]), .mem_rdata_we(o_mwe[0]), .exe_we(o_exe[0]), .rf_we(o_rfwe[0]),
    .state(o_st[0]), .retire(o_ret[0]), .cycle_cnt(o_cyc0), .instret_cnt(o_ret0),
    .debug_wb_pc(o_dpc[0]), .debug_wb_rf_we(o_dwe4[0])
  );

  multicycle_ctrl #(.IMEM_LAT(3), .DMEM_LAT(2), .SKIP_MEM(0), .CNT_W(4)) u1 (
    .clk(clk), .reset(rst[1]), .inst_sram_rdata(rdata[1]), .dec_is_load(dld[1]),
    .dec_is_store(dst[1]), .dec_gr_we(dwe[1]), .br_taken(dbt[1]), .br_target(dbtg[1]),
    .pc(o_pc[1]), .ir(o_ir[1]), .inst_sram_en(o_ien[1]), .data_sram_en(o_den[1]),
    .data_sram_we(o_dwe[1]), .mem_rdata_we(o_mwe[1]), .exe_we(o_exe[1]), .rf_we(o_rfwe[1]),
    .state(o_st[1]), .retire(o_ret[1]), .cycle_cnt(o_cyc1), .instret_cnt(o_ret1),
    .debug_wb_pc(o_dpc[1]), .debug_wb_rf_we(o_dwe4[1])
  );

  int          il[2] = '{1, 3};
  int          dl[2] = '{1, 2};
  int          sk[2] = '{1, 0};
  logic [31:0] cm[2] = '{32'hffffffff, 32'h0000000f};
  int          pos[2];
  bit          vld[2], ld[2], st[2], we[2], bt[2];
  logic [31:0] inst[2], btg[2], mpc[2], mir[2], mcyc[2], mret[2];
  int          checks = 0, failures = 0, cd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL u%0d.%s t=%0t got=%h exp=%h", cd, tag, $time, got, exp);
    end
  endtask

  function automatic int mlen(input int d);
    return ld[d] ? dl[d] : st[d] ? 1 : (sk[d] != 0 ? 0 : 1);
  endfunction

  // phase derived from position within the instruction: IF x il, ID, EXE, MEM x mlen, WB
  function automatic logic [2:0] phase(input int d);
    if (pos[d] < il[d]) return 3'd0;
    if (pos[d] == il[d]) return 3'd1;
    if (pos[d] == il[d] + 1) return 3'd2;
    if (pos[d] < il[d] + 2 + mlen(d)) return 3'd3;
    return 3'd4;
  endfunction

  task automatic new_inst(input int d);
    int k = $urandom_range(0, 7);
    ld[d]   = k <= 1 || k == 4;
    st[d]   = k == 2 || k == 3 || k == 4;
    we[d]   = 1'($urandom);
    bt[d]   = 1'($urandom);
    btg[d]  = $urandom;
    inst[d] = $urandom;
    pos[d]  = 0;
  endtask

  task automatic drive(input int d, input int c);
    logic [2:0] ph = phase(d);
    rdata[d] = pos[d] == il[d] - 1 ? inst[d] : $urandom;
    dld[d]   = ph == 3'd1 ? ld[d] : 1'($urandom);
    dst[d]   = ph == 3'd1 ? st[d] : 1'($urandom);
    dwe[d]   = ph == 3'd1 ? we[d] : 1'($urandom);
    dbt[d]   = ph == 3'd2 ? bt[d] : 1'($urandom);
    dbtg[d]  = ph == 3'd2 ? btg[d] : $urandom;
    rst[d]   = c < 2 || (ph == 3'd3 && st[d] && !ld[d] && $urandom_range(0, 9) == 0)
               || $urandom_range(0, 399) == 0;
  endtask

  task automatic verify(input int d);
    logic [2:0] ph = phase(d);
    bit         lv = !rst[d];
    bit         wb = lv && ph == 3'd4;
    logic [31:0] cyc = d == 0 ? o_cyc0 : {28'd0, o_cyc1};
    logic [31:0] ret = d == 0 ? o_ret0 : {28'd0, o_ret1};
    cd = d;
    check("inst_en", 32'(o_ien[d]), 32'(lv && ph == 3'd0));
    check("data_en", 32'(o_den[d]), 32'(lv && ph == 3'd3 && (ld[d] || st[d])));
    check("data_we", 32'(o_dwe[d]), 32'(lv && ph == 3'd3 && st[d] && !ld[d]));
    check("mem_rdata_we", 32'(o_mwe[d]), 32'(lv && ph == 3'd3 && ld[d] && pos[d] == il[d] + 1 + dl[d]));
    check("exe_we", 32'(o_exe[d]), 32'(lv && ph == 3'd2));
    check("rf_we", 32'(o_rfwe[d]), 32'(wb && we[d]));
    check("retire", 32'(o_ret[d]), 32'(wb));
    check("dbg_pc", o_dpc[d], (wb && we[d]) ? mpc[d] : 32'd0);
    check("dbg_we", 32'(o_dwe4[d]), 32'({4{wb && we[d]}}));
    if (vld[d]) begin
      check("state", 32'(o_st[d]), 32'(ph));
      check("pc", o_pc[d], mpc[d]);
      check("ir", o_ir[d], mir[d]);
      check("cycle_cnt", cyc, mcyc[d]);
      check("instret_cnt", ret, mret[d]);
    end
  endtask

  task automatic step(input int d);
    if (rst[d]) begin
      vld[d] = 1'b1; mpc[d] = PCR; mir[d] = '0; mcyc[d] = '0; mret[d] = '0;
      new_inst(d);
    end else begin
      mcyc[d] = (mcyc[d] + 1) & cm[d];
      if (pos[d] == il[d] - 1) mir[d] = inst[d];
      if (phase(d) == 3'd4) begin
        mpc[d]  = bt[d] ? (btg[d] & ~32'd3) : mpc[d] + 32'd4;
        mret[d] = (mret[d] + 1) & cm[d];
        new_inst(d);
      end else pos[d]++;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; mpc[d] = '0; mir[d] = '0; mcyc[d] = '0; mret[d] = '0;
      new_inst(d);
    end
    for (int c = 0; c < 4000; c++) begin
      for (int d = 0; d < 2; d++) drive(d, c);
      @(negedge clk);
      for (int d = 0; d < 2; d++) verify(d);
      @(posedge clk);
      for (int d = 0; d < 2; d++) step(d);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
